// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock into a register file,
// read back by round index with one cycle of latency for the inverse key-add stage.
module aes_inv_key_schedule #(
  parameter int unsigned NR  = 10,
  parameter int unsigned RKW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0][7:0]     key_in,
  output logic                 busy,
  output logic                 key_valid,
  input  logic [RKW-1:0]       rd_round,
  output logic [15:0][7:0]     rd_key
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [RKW-1:0] LastRound = RKW'(NR);

  typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

  state_e            state_q, state_d;
  logic [RKW-1:0]    cnt_q;
  logic [15:0][7:0]  rk_q [NR+1];
  logic              load, step;
  logic [7:0]        rcon;
  logic [15:0][7:0]  prev_key, next_key;
  logic [31:0]       rot_w, sub_w;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // MSB index of entry b is 2047 - 8*b, i.e. {~b, 3'b111}.
    return SboxTab[{~b, 3'b111} -: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StExpand;
      StExpand: if (cnt_q == LastRound) state_d = StReady;
      StReady:  if (start) state_d = StExpand;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StExpand);
    key_valid = (state_q == StReady);
    step      = (state_q == StExpand);
    load      = start && (state_q != StExpand);
  end

  always_comb begin
    rcon = 8'h00;
    case (cnt_q)
      RKW'(1):  rcon = 8'h01;
      RKW'(2):  rcon = 8'h02;
      RKW'(3):  rcon = 8'h04;
      RKW'(4):  rcon = 8'h08;
      RKW'(5):  rcon = 8'h10;
      RKW'(6):  rcon = 8'h20;
      RKW'(7):  rcon = 8'h40;
      RKW'(8):  rcon = 8'h80;
      RKW'(9):  rcon = 8'h1b;
      RKW'(10): rcon = 8'h36;
      default:  rcon = 8'h00;
    endcase
  end

  always_comb begin
    next_key = '0;
    prev_key = rk_q[cnt_q - RKW'(1)];
    rot_w    = {prev_key[3:0]};
    rot_w    = {rot_w[23:0], rot_w[31:24]};
    sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    next_key[15:12] = prev_key[15:12] ^ sub_w ^ {rcon, 24'h000000};
    next_key[11:8]  = prev_key[11:8] ^ next_key[15:12];
    next_key[7:4]   = prev_key[7:4] ^ next_key[11:8];
    next_key[3:0]   = prev_key[3:0] ^ next_key[7:4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      rd_key <= '0;
    end else begin
      if (load)      cnt_q <= RKW'(1);
      else if (step) cnt_q <= cnt_q + RKW'(1);
      rd_key <= (rd_round <= LastRound) ? rk_q[rd_round] : '0;
    end
  end

  // Key file is never cleared; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load)      rk_q[0]     <= key_in;
      else if (step) rk_q[cnt_q] <= next_key;
    end
  end

endmodule
